fixed_to_dac_spi: RTL and testbench



---
 rtl/fixed_to_dac_spi.sv | 201 ++++++++++++++++++++
 tb/tb_fixed_to_dac_spi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_dac_spi.sv
// Signed fixed-point samples -> offset-binary 16-bit frames on a write-only SPI DAC (mode 0).
// Optional macro DAC_LDAC_EN adds an active-low LDAC pulse after each frame.
module fixed_to_dac_spi #(
    parameter int         FIXED_WIDTH = 12,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SCLK_DIV    = 2,
    parameter logic [3:0] CTRL_BITS   = 4'h3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [FIXED_WIDTH-1:0] d,
    output logic                   ready,
    output logic                   overflow,
    output logic                   busy,
    output logic                   dac_sclk,
    output logic                   dac_cs_n,
    output logic                   dac_din
`ifdef DAC_LDAC_EN
    ,
    output logic                   dac_ldac_n
`endif
);
    localparam int FRAME_W = FIXED_WIDTH + 4;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int DW      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW      = $clog2(FRAME_W);
    localparam logic [DW-1:0]          DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [FIXED_WIDTH-1:0] SIGN_FLIP = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
`ifdef DAC_LDAC_EN
        ,
        S_LDAC
`endif
    } state_t;

    logic [FIXED_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;

    state_t                 r_state;
    logic [DW-1:0]          r_div;
    logic [BW-1:0]          r_bit;
    logic                   r_high;
    logic [FRAME_W-1:0]     r_shift;
    logic                   r_sclk;
    logic                   r_cs_n;
    logic                   r_din;
`ifdef DAC_LDAC_EN
    logic                   r_ldac_n;
`endif

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = en && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    // Samples are stored already converted to offset-binary.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= d ^ SIGN_FLIP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (en && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_high   <= 1'b0;
            r_shift  <= '0;
            r_sclk   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_din    <= 1'b0;
`ifdef DAC_LDAC_EN
            r_ldac_n <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= {CTRL_BITS, r_fifo[r_rd_ptr]};
                        r_din   <= CTRL_BITS[3];
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_bit   <= BW'(FRAME_W - 1);
                        r_high  <= 1'b0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + DW'(1);
                    end else begin
                        r_div <= '0;
                        if (!r_high) begin
                            r_high <= 1'b1;
                            r_sclk <= 1'b1;
                        end else begin
                            // End of a high phase: next data bit goes out with the falling sclk.
                            r_high <= 1'b0;
                            r_sclk <= 1'b0;
                            if (r_bit == '0) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit <= r_bit - BW'(1);
                                r_din <= r_shift[r_bit - BW'(1)];
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_cs_n  <= 1'b1;
                        r_din   <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                S_GAP: begin
                    if (r_div == DIV_LAST) begin
                        r_div    <= '0;
`ifdef DAC_LDAC_EN
                        r_ldac_n <= 1'b0;
                        r_state  <= S_LDAC;
`else
                        r_state  <= S_IDLE;
`endif
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
`ifdef DAC_LDAC_EN
                S_LDAC: begin
                    if (r_div == DIV_LAST) begin
                        r_div    <= '0;
                        r_ldac_n <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready    = !w_full;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign dac_sclk = r_sclk;
    assign dac_cs_n = r_cs_n;
    assign dac_din  = r_din;
`ifdef DAC_LDAC_EN
    assign dac_ldac_n = r_ldac_n;
`endif
endmodule

// File: tb/tb_fixed_to_dac_spi.sv
// Self-checking bench for fixed_to_dac_spi: directed plus random samples against a queue-based frame model.
module tb_fixed_to_dac_spi;
    localparam int D = 2;
`ifdef DAC_LDAC_EN
    localparam int PERIOD = 36 * D + 1;
`else
    localparam int PERIOD = 35 * D + 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] d = '0;
    logic        ready, overflow, busy, dac_sclk, dac_cs_n, dac_din;
`ifdef DAC_LDAC_EN
    logic        dac_ldac_n;
`endif

    fixed_to_dac_spi dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d),
        .ready(ready), .overflow(overflow), .busy(busy),
        .dac_sclk(dac_sclk), .dac_cs_n(dac_cs_n), .dac_din(dac_din)
`ifdef DAC_LDAC_EN
        , .dac_ldac_n(dac_ldac_n)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial-side observer: rebuilds each frame from sclk rising edges.
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic [15:0] acc = '0;
    int          nbits = 0;
    int          low_len = 0;
    int          fall_cyc = 0;
    int          sclk_rises = 0;
    logic [15:0] q_frame[$];
    int          q_nbits[$];
    int          q_low[$];
    int          q_fall[$];
`ifdef DAC_LDAC_EN
    logic        prev_ldac = 1'b1;
    int          rise_cyc = 0;
    int          ldac_fall = 0;
    int          q_ldac_off[$];
    int          q_ldac_len[$];
`endif

    always @(negedge clk) begin
        if (!dac_cs_n && prev_cs) begin
            fall_cyc = cyc;
            low_len  = 0;
            nbits    = 0;
            acc      = '0;
        end
        if (dac_sclk && !prev_sclk) begin
            acc = {acc[14:0], dac_din};
            nbits++;
            sclk_rises++;
        end
        if (!dac_cs_n) low_len++;
        if (dac_cs_n && !prev_cs) begin
            q_frame.push_back(acc);
            q_nbits.push_back(nbits);
            q_low.push_back(low_len);
            q_fall.push_back(fall_cyc);
`ifdef DAC_LDAC_EN
            rise_cyc = cyc;
`endif
        end
`ifdef DAC_LDAC_EN
        if (!dac_ldac_n && prev_ldac) ldac_fall = cyc;
        if (dac_ldac_n && !prev_ldac) begin
            q_ldac_off.push_back(ldac_fall - rise_cyc);
            q_ldac_len.push_back(cyc - ldac_fall);
        end
        prev_ldac = dac_ldac_n;
`endif
        prev_sclk = dac_sclk;
        prev_cs   = dac_cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: offset-binary is the signed value shifted up by half-scale.
    function automatic logic [15:0] model(input logic [11:0] s);
        int u;
        u = (s[11] ? int'(s) - 4096 : int'(s)) + 2048;
        return {4'h3, 12'(u)};
    endfunction

    task automatic send(input logic [11:0] v, output int en_edge);
        d  = v;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        en_edge = cyc;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (q_frame.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait", 32'(q_frame.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic clear_queues();
        q_frame.delete();
        q_nbits.delete();
        q_low.delete();
        q_fall.delete();
`ifdef DAC_LDAC_EN
        q_ldac_off.delete();
        q_ldac_len.delete();
`endif
    endtask

    initial begin
        int          e;
        int          k;
        int          r;
        logic [11:0] v;
        logic [15:0] exp_q[$];
        logic [11:0] vals [5];
        int          fall_prev;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_cs_n", 32'(dac_cs_n), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_din", 32'(dac_din), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sample, timing of one frame
        send(12'h000, e);
        wait_frames(1, 300);
        if (q_frame.size() > 0) begin
            check("single_frame", 32'(q_frame[0]), 32'(model(12'h000)));
            check("single_nbits", 32'(q_nbits[0]), 32'd16);
            check("single_cs_low", 32'(q_low[0]), 32'(34 * D));
            check("single_latency", 32'(q_fall[0] - e), 32'd1);
        end
        wait_idle(50);
`ifdef DAC_LDAC_EN
        if (q_ldac_off.size() > 0) begin
            check("ldac_offset", 32'(q_ldac_off[0]), 32'(D));
            check("ldac_len", 32'(q_ldac_len[0]), 32'(D));
        end else begin
            check("ldac_seen", 32'(q_ldac_off.size()), 32'd1);
        end
`endif
        clear_queues();

        // Code extremes and a couple of random values, one at a time
        vals[0] = 12'h7FF;
        vals[1] = 12'h800;
        vals[2] = 12'h001;
        vals[3] = 12'($urandom);
        vals[4] = 12'($urandom);
        for (int i = 0; i < 5; i++) begin
            send(vals[i], e);
            wait_frames(1, 300);
            if (q_frame.size() > 0) check("extreme_frame", 32'(q_frame[0]), 32'(model(vals[i])));
            wait_idle(50);
            clear_queues();
        end

        // Burst of six strobes: five accepted, sixth dropped
        for (int i = 1; i <= 6; i++) begin
            d  = 12'(i);
            en = 1'b1;
            if (i == 5) check("burst_ready_5", 32'(ready), 32'd1);
            if (i == 6) check("burst_ready_6", 32'(ready), 32'd0);
            @(negedge clk);
        end
        en = 1'b0;
        check("burst_overflow", 32'(overflow), 32'd1);
        wait_frames(5, 6 * PERIOD + 50);
        wait_idle(100);
        check("burst_count", 32'(q_frame.size()), 32'd5);
        for (int i = 0; i < 5 && i < q_frame.size(); i++) begin
            check("burst_frame", 32'(q_frame[i]), 32'(model(12'(i + 1))));
            if (i > 0) check("burst_period", 32'(q_fall[i] - q_fall[i-1]), 32'(PERIOD));
        end
        check("overflow_sticky", 32'(overflow), 32'd1);
        clear_queues();

        // Random stream with random gaps, honouring ready
        for (int i = 0; i < 12; i++) begin
            k = 0;
            while (!ready && k < 500) begin
                @(negedge clk);
                k++;
            end
            check("stream_ready_wait", 32'(ready), 32'd1);
            v = 12'($urandom);
            exp_q.push_back(model(v));
            send(v, e);
            repeat ($urandom_range(0, 80)) @(negedge clk);
        end
        wait_frames(12, 12 * PERIOD + 100);
        wait_idle(100);
        check("stream_count", 32'(q_frame.size()), 32'd12);
        for (int i = 0; i < 12 && i < q_frame.size(); i++) begin
            check("stream_frame", 32'(q_frame[i]), 32'(exp_q[i]));
            check("stream_nbits", 32'(q_nbits[i]), 32'd16);
        end
        check("stream_overflow", 32'(overflow), 32'd1);
        clear_queues();

        // Mid-frame reset with a second sample still queued
        send(12'($urandom), e);
        send(12'($urandom), e);
        k = 0;
        while (!(!dac_cs_n && nbits == 8) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("midrst_reach_bit8", 32'(nbits), 32'd8);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", 32'(dac_cs_n), 32'd1);
        check("midrst_sclk", 32'(dac_sclk), 32'd0);
        check("midrst_din", 32'(dac_din), 32'd0);
        r = sclk_rises;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("midrst_no_edges", 32'(sclk_rises - r), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_cs_idle", 32'(dac_cs_n), 32'd1);
        clear_queues();

        // Recovery: a fresh sample after the abandoned frame
        v = 12'($urandom);
        send(v, e);
        wait_frames(1, 300);
        if (q_frame.size() > 0) check("recover_frame", 32'(q_frame[0]), 32'(model(v)));
        fall_prev = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
